// File: rtl/muldiv_unit_pkg.sv
// Shared op encodings, FSM states and sizing for the multiply/divide engine.
package muldiv_unit_pkg;

    localparam int unsigned DATA_W    = 32;
    localparam int unsigned DIV_ITERS = 32;

    typedef enum logic [2:0] {
        MD_MULT  = 3'd0,
        MD_MULTU = 3'd1,
        MD_DIV   = 3'd2,
        MD_DIVU  = 3'd3,
        MD_MADD  = 3'd4,
        MD_MADDU = 3'd5,
        MD_MSUB  = 3'd6,
        MD_MSUBU = 3'd7
    } md_op_e;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        MUL  = 3'd1,
        DIV  = 3'd2,
        FIX  = 3'd3,
        DONE = 3'd4
    } md_state_e;

endpackage

// File: rtl/muldiv_unit_div_core.sv
// Restoring radix-2 divider on unsigned magnitudes, one quotient bit per cycle.
module muldiv_unit_div_core
#(
    parameter int unsigned W = 32
)(
    input  logic         clk,
    input  logic         rst,
    input  logic         clear,
    input  logic         start,
    input  logic [W-1:0] dividend,
    input  logic [W-1:0] divisor,
    output logic [W-1:0] quotient,
    output logic [W-1:0] remainder,
    output logic         div_by_zero,
    output logic         done_c
);
    import muldiv_unit_pkg::*;

    localparam int unsigned CNT_W = $clog2(DIV_ITERS);

    logic [W-1:0]     quo_q;
    logic [W-1:0]     rem_q;
    logic [W-1:0]     dvs_q;
    logic [CNT_W-1:0] cnt_q;
    logic             run_q;
    logic             dbz_q;
    logic [W:0]       rem_sh;
    logic [W:0]       diff;
    logic             fits;

    // Trial subtraction: shift in the next dividend bit, keep the difference if non-negative.
    always_comb begin
        rem_sh = {rem_q, quo_q[W-1]};
        diff   = rem_sh - {1'b0, dvs_q};
        fits   = ~diff[W];
        done_c = run_q && (cnt_q == CNT_W'(DIV_ITERS - 1));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            quo_q <= '0;
            rem_q <= '0;
            dvs_q <= '0;
            cnt_q <= '0;
            run_q <= 1'b0;
            dbz_q <= 1'b0;
        end else if (clear) begin
            cnt_q <= '0;
            run_q <= 1'b0;
        end else if (start) begin
            quo_q <= dividend;
            rem_q <= '0;
            dvs_q <= divisor;
            cnt_q <= '0;
            run_q <= 1'b1;
            dbz_q <= (divisor == '0);
        end else if (run_q) begin
            quo_q <= {quo_q[W-2:0], fits};
            rem_q <= fits ? diff[W-1:0] : rem_sh[W-1:0];
            cnt_q <= cnt_q + CNT_W'(1);
            if (done_c) begin
                run_q <= 1'b0;
            end
        end
    end

    assign quotient    = quo_q;
    assign remainder   = rem_q;
    assign div_by_zero = dbz_q;

endmodule

// File: rtl/muldiv_unit.sv
// EX-stage multi-cycle multiply/divide engine producing HILO write data and strobe.
// Define MULDIV_ACC_EN to enable MADD/MADDU/MSUB/MSUBU accumulation into hilo_cur.
module muldiv_unit
#(
    parameter int unsigned MUL_LAT = 2,
    parameter int unsigned DATA_W  = 32
)(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [2:0]            op,
    input  logic [DATA_W-1:0]     src_a,
    input  logic [DATA_W-1:0]     src_b,
    input  logic [2*DATA_W-1:0]   hilo_cur,
    input  logic                  cancel,
    output logic                  busy,
    output logic                  hilo_we,
    output logic [2*DATA_W-1:0]   hilo_wdata
);
    import muldiv_unit_pkg::*;

    localparam int unsigned W2 = 2 * DATA_W;

    md_state_e         state_q;
    logic [3:0]        cnt_q;
    logic [W2-1:0]     prod_q;
    logic [DATA_W-1:0] a_q;
    logic              q_neg_q;
    logic              r_neg_q;

    logic              accept;
    logic              is_div;
    logic              mul_sgn;
    logic              a_neg;
    logic              b_neg;
    logic [DATA_W-1:0] mag_a;
    logic [DATA_W-1:0] mag_b;
    logic [W2-1:0]     a_ext;
    logic [W2-1:0]     b_ext;
    logic [W2-1:0]     product;
    logic [3:0]        mul_cycles;
    logic [W2-1:0]     mul_res;
    logic [W2-1:0]     div_res;

    logic [DATA_W-1:0] quo;
    logic [DATA_W-1:0] rem;
    logic              div_dbz;
    logic              div_done_c;

`ifdef MULDIV_ACC_EN
    logic [W2-1:0]     acc_q;
    logic [1:0]        acc_mode_q;   // 0: plain product, 1: add, 2: subtract
`else
    logic              unused_hilo_cur;
    assign unused_hilo_cur = ^hilo_cur;
`endif

    always_comb begin
        accept  = start && !cancel && (state_q == IDLE);
        is_div  = (op == MD_DIV) || (op == MD_DIVU);
        mul_sgn = ~op[0];
        a_neg   = (op == MD_DIV) && src_a[DATA_W-1];
        b_neg   = (op == MD_DIV) && src_b[DATA_W-1];
        mag_a   = a_neg ? -src_a : src_a;
        mag_b   = b_neg ? -src_b : src_b;
        // Sign-extend to full width so the truncated product is the exact 2N-bit result.
        a_ext   = {{DATA_W{mul_sgn & src_a[DATA_W-1]}}, src_a};
        b_ext   = {{DATA_W{mul_sgn & src_b[DATA_W-1]}}, src_b};
        product = a_ext * b_ext;
`ifdef MULDIV_ACC_EN
        mul_cycles = 4'(MUL_LAT - 1) + {3'b000, op[2]};
        unique case (acc_mode_q)
            2'd1:    mul_res = acc_q + prod_q;
            2'd2:    mul_res = acc_q - prod_q;
            default: mul_res = prod_q;
        endcase
`else
        mul_cycles = 4'(MUL_LAT - 1);
        mul_res    = prod_q;
`endif
        if (div_dbz) begin
            div_res = {a_q, {DATA_W{1'b1}}};
        end else begin
            div_res = {(r_neg_q ? -rem : rem), (q_neg_q ? -quo : quo)};
        end
    end

    muldiv_unit_div_core #(.W(DATA_W)) u_div_core (
        .clk         (clk),
        .rst         (rst),
        .clear       (cancel),
        .start       (accept && is_div),
        .dividend    (mag_a),
        .divisor     (mag_b),
        .quotient    (quo),
        .remainder   (rem),
        .div_by_zero (div_dbz),
        .done_c      (div_done_c)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            prod_q     <= '0;
            a_q        <= '0;
            q_neg_q    <= 1'b0;
            r_neg_q    <= 1'b0;
            busy       <= 1'b0;
            hilo_we    <= 1'b0;
            hilo_wdata <= '0;
`ifdef MULDIV_ACC_EN
            acc_q      <= '0;
            acc_mode_q <= 2'd0;
`endif
        end else begin
            hilo_we <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (accept) begin
                        busy    <= 1'b1;
                        a_q     <= src_a;
                        q_neg_q <= a_neg ^ b_neg;
                        r_neg_q <= a_neg;
                        prod_q  <= product;
                        cnt_q   <= mul_cycles - 4'd1;
`ifdef MULDIV_ACC_EN
                        acc_q      <= hilo_cur;
                        acc_mode_q <= op[2] ? (op[1] ? 2'd2 : 2'd1) : 2'd0;
`endif
                        if (is_div) begin
                            state_q <= DIV;
                        end else if (mul_cycles == 4'd0) begin
                            state_q    <= DONE;
                            hilo_we    <= 1'b1;
                            hilo_wdata <= product;
                        end else begin
                            state_q <= MUL;
                        end
                    end
                end
                MUL: begin
                    if (cnt_q == 4'd0) begin
                        state_q    <= DONE;
                        hilo_we    <= 1'b1;
                        hilo_wdata <= mul_res;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                DIV: begin
                    if (div_done_c) begin
                        state_q <= FIX;
                    end
                end
                FIX: begin
                    state_q    <= DONE;
                    hilo_we    <= 1'b1;
                    hilo_wdata <= div_res;
                end
                DONE: begin
                    state_q <= IDLE;
                    busy    <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                    busy    <= 1'b0;
                end
            endcase
            // An abort suppresses any write not yet on the output.
            if (cancel) begin
                state_q <= IDLE;
                busy    <= 1'b0;
                hilo_we <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Randomized self-checking bench for muldiv_unit against an arithmetic reference model.
module tb_muldiv_unit;

    localparam int unsigned MUL_LAT = 2;
`ifdef MULDIV_ACC_EN
    localparam bit ACC_EN = 1'b1;
`else
    localparam bit ACC_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [2:0]  op;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic [63:0] hilo_cur;
    logic        cancel;
    logic        busy;
    logic        hilo_we;
    logic [63:0] hilo_wdata;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    muldiv_unit #(.MUL_LAT(MUL_LAT), .DATA_W(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .op         (op),
        .src_a      (src_a),
        .src_b      (src_b),
        .hilo_cur   (hilo_cur),
        .cancel     (cancel),
        .busy       (busy),
        .hilo_we    (hilo_we),
        .hilo_wdata (hilo_wdata)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference: {HI,LO} from plain signed/unsigned arithmetic.
    function automatic logic [63:0] model(input logic [2:0] o, input logic [31:0] a,
                                          input logic [31:0] b, input logic [63:0] cur);
        longint      sa;
        longint      sb;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        if (o == 3'd2 || o == 3'd3) begin
            if (b == 32'd0) return {a, 32'hFFFF_FFFF};
            if (o == 3'd2) return {32'(sa % sb), 32'(sa / sb)};
            return {a % b, a / b};
        end
        if (o == 3'd0 || o == 3'd4 || o == 3'd6) p = 64'(sa * sb);
        else                                     p = {32'd0, a} * {32'd0, b};
        if (ACC_EN && (o == 3'd4 || o == 3'd5)) return cur + p;
        if (ACC_EN && (o == 3'd6 || o == 3'd7)) return cur - p;
        return p;
    endfunction

    function automatic int exp_lat(input logic [2:0] o);
        if (o == 3'd2 || o == 3'd3) return 34;
        return int'(MUL_LAT) + ((ACC_EN && o[2]) ? 1 : 0);
    endfunction

    task automatic scramble();
        op       = 3'($urandom);
        src_a    = $urandom;
        src_b    = $urandom;
        hilo_cur = {$urandom, $urandom};
    endtask

    // Called at a negedge in an idle cycle; returns one cycle after the write cycle.
    task automatic run_op(input string tag, input logic [2:0] o, input logic [31:0] a,
                          input logic [31:0] b, input logic [63:0] cur,
                          input int stray_at, input bit cancel_at_we);
        logic [63:0] exp_d;
        int          k;
        exp_d    = model(o, a, b, cur);
        start    = 1'b1;
        op       = o;
        src_a    = a;
        src_b    = b;
        hilo_cur = cur;
        @(negedge clk);
        start = 1'b0;
        scramble();
        check({tag, "_busy_n1"}, 64'(busy), 64'd1);
        k = 1;
        while (!hilo_we && k < 60) begin
            start = (k == stray_at);
            @(negedge clk);
            k++;
        end
        start = 1'b0;
        check({tag, "_latency"}, 64'(k), 64'(exp_lat(o)));
        check({tag, "_wdata"}, hilo_wdata, exp_d);
        check({tag, "_busy_we"}, 64'(busy), 64'd1);
        cancel = cancel_at_we;
        @(negedge clk);
        cancel = 1'b0;
        check({tag, "_we_pulse"}, 64'(hilo_we), 64'd0);
        check({tag, "_busy_after"}, 64'(busy), 64'd0);
    endtask

    task automatic expect_quiet(input string tag, input int n);
        int writes = 0;
        repeat (n) begin
            @(negedge clk);
            if (hilo_we) writes++;
        end
        check(tag, 64'(writes), 64'd0);
    endtask

    initial begin
        logic [2:0]  o;
        logic [31:0] a;
        logic [31:0] b;
        rst    = 1'b1;
        start  = 1'b0;
        cancel = 1'b0;
        scramble();
        repeat (3) @(negedge clk);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_we", 64'(hilo_we), 64'd0);
        check("rst_wdata", hilo_wdata, 64'd0);
        rst = 1'b0;
        @(negedge clk);

        run_op("mult", 3'd0, 32'hFFFF_FFFE, 32'd3, 64'd0, 0, 1'b0);
        run_op("multu", 3'd1, 32'hFFFF_FFFE, 32'd3, 64'd0, 0, 1'b0);
        run_op("div_neg", 3'd2, 32'hFFFF_FFF9, 32'd2, 64'd0, 0, 1'b0);
        run_op("divu", 3'd3, 32'd100, 32'd7, 64'd0, 0, 1'b0);
        run_op("div_zero", 3'd2, 32'h1234_5678, 32'd0, 64'd0, 0, 1'b0);
        run_op("div_ovf", 3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 64'd0, 0, 1'b0);
        run_op("div_stray", 3'd2, 32'hDEAD_BEEF, 32'h0000_1234, 64'd0, 5, 1'b0);
        run_op("mult_cancel_we", 3'd0, 32'h0001_0000, 32'h0001_0000, 64'd0, 0, 1'b1);
`ifdef MULDIV_ACC_EN
        run_op("maddu", 3'd5, 32'd1, 32'd1, 64'h0000_0000_FFFF_FFFF, 0, 1'b0);
        run_op("msub", 3'd6, 32'd1, 32'd1, 64'd0, 0, 1'b0);
`endif

        // Abort a divide mid-flight, then restart two cycles later.
        start = 1'b1; op = 3'd3; src_a = 32'd1000; src_b = 32'd3;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        cancel = 1'b1;
        @(negedge clk);
        cancel = 1'b0;
        check("cancel_busy", 64'(busy), 64'd0);
        check("cancel_we", 64'(hilo_we), 64'd0);
        @(negedge clk);
        run_op("after_cancel", 3'd3, 32'd77, 32'd5, 64'd0, 0, 1'b0);

        // Start together with cancel must not launch anything.
        start = 1'b1; cancel = 1'b1; op = 3'd0; src_a = 32'd9; src_b = 32'd9;
        @(negedge clk);
        start = 1'b0; cancel = 1'b0;
        check("start_cancel_busy", 64'(busy), 64'd0);
        expect_quiet("start_cancel_quiet", 40);

        // Synchronous reset in the middle of a divide.
        start = 1'b1; op = 3'd2; src_a = 32'h7777_0000; src_b = 32'd13;
        @(negedge clk);
        start = 1'b0;
        repeat (6) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst_busy", 64'(busy), 64'd0);
        check("midrst_wdata", hilo_wdata, 64'd0);
        expect_quiet("midrst_quiet", 40);

        for (int i = 0; i < 60; i++) begin
            o = 3'($urandom);
            a = $urandom;
            b = $urandom;
            case ($urandom_range(0, 7))
                0:       b = 32'd0;
                1:       begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                2:       b = 32'($urandom_range(1, 15));
                default: ;
            endcase
            run_op($sformatf("rnd%0d_op%0d", i, o), o, a, b, {$urandom, $urandom},
                   ($urandom_range(0, 3) == 0) ? int'($urandom_range(2, 6)) : 0, 1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Multi-cycle multiply/divide engine in the EX stage.
- Produces the 64-bit {HI,LO} write data and the write strobe consumed directly by the HILO register.
- The pipeline stalls on busy while an operation is in flight.
- A cancel input aborts work squashed by exceptions or flushes.

Parameters:
- MUL_LAT, 2, cycles from the start cycle to the hilo_we pulse for multiply ops (legal 1..8).
- DATA_W, 32, operand width; the result is 2*DATA_W.

Ports:
- clk  input  1  clock, all state on posedge
- rst  input  1  reset, synchronous, active-high
- start  input  1  launch an operation; accepted only when busy=0 and cancel=0
- op  input  3  0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MADD, 5 MADDU, 6 MSUB, 7 MSUBU
- src_a  input  DATA_W  rs operand (dividend / multiplicand)
- src_b  input  DATA_W  rt operand (divisor / multiplier)
- hilo_cur  input  2*DATA_W  current HILO value, used only by accumulate ops
- cancel  input  1  abort the in-flight op; no write is produced
- busy  output  1  operation in flight, pipeline must stall
- hilo_we  output  1  one-cycle write strobe to the HILO register
- hilo_wdata  output  2*DATA_W  {HI,LO} result, valid while hilo_we=1

Behaviour:
- Reset values: state IDLE; busy=0, hilo_we=0, hilo_wdata=0; all counters 0.
- Operands, op and (for accumulate ops) hilo_cur are captured on the accept edge. Later input changes have no effect.
- State machine:
  - IDLE -> MUL on an accepted op 0,1,4,5,6,7; IDLE -> DIV on op 2,3.
  - MUL: counts MUL_LAT-1 cycles, then -> DONE.
  - DIV: restoring radix-2, exactly 32 iteration cycles on magnitudes, then -> FIX.
  - FIX: applies sign correction, registers the result, then -> DONE.
  - DONE: hilo_we=1 for exactly one cycle, then -> IDLE.
- Latency, with start accepted in cycle N:
  - Multiply: hilo_we high in cycle N+MUL_LAT.
  - Divide: hilo_we high in cycle N+34.
- busy: high from N+1 through the hilo_we cycle inclusive; low in IDLE.
- Back-to-back: a new start is accepted in the cycle after hilo_we.
- Multiply:
  - MULT is signed 32x32->64; MULTU is unsigned.
  - hilo_wdata = {hi,lo} of the product.
- Divide (LO = quotient, HI = remainder):
  - DIV truncates toward zero; the remainder takes the sign of the dividend.
  - DIVU is unsigned.
- Divide boundary cases:
  - Divide by zero: LO=all-ones, HI=src_a. Completes with normal latency and never hangs.
  - Signed overflow 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0.
- start while busy=1: ignored, with no effect on the current op.
- cancel:
  - Synchronous; any state -> IDLE on the next edge.
  - busy=0 next cycle, and no hilo_we for the aborted op.
  - cancel in the same cycle as hilo_we: the write still occurs (already committed).
  - cancel together with start: start is ignored.
- rst mid-operation: same as cancel, and hilo_wdata is cleared.

Optional Feature:
- MULDIV_ACC_EN defined:
  - MADD/MADDU: hilo_wdata = hilo_cur + product.
  - MSUB/MSUBU: hilo_wdata = hilo_cur - product.
  - Arithmetic is 64-bit modulo 2^64 (wraps).
  - Latency is MUL_LAT+1, with one extra accumulate cycle in MUL.
- MULDIV_ACC_EN undefined:
  - ops 4-7 are treated as MULT/MULTU (4,6 signed; 5,7 unsigned).
  - hilo_cur is unused.

Decomposition:
- Shared package:
  - op encoding constants (MD_MULT..MD_MSUBU)
  - FSM state enum (IDLE, MUL, DIV, FIX, DONE)
  - DIV_ITERS=32 constant
  - DATA_W default
- Natural sub-module: div_core. It holds the 32-iteration restoring divider on unsigned magnitudes, with start/done and a divide-by-zero flag. The parent owns signs, multiply and the FSM.

Test Plan:
- MULT 0xFFFFFFFE x 0x00000003, MUL_LAT=2 -> hilo_we at N+2, wdata=0xFFFFFFFF_FFFFFFFA. MULTU with the same operands -> 0x00000002_FFFFFFFA.
- DIV 0xFFFFFFF9 (-7) / 2 -> hilo_we at N+34, HI=0xFFFFFFFF, LO=0xFFFFFFFD. DIVU 100/7 -> HI=2, LO=14.
- DIV x/0 with x=0x12345678 -> completes at N+34, HI=0x12345678, LO=0xFFFFFFFF. DIV 0x80000000/0xFFFFFFFF -> LO=0x80000000, HI=0.
- DIVU started, cancel at N+10 -> busy low at N+11, no hilo_we ever. A start at N+12 is accepted normally.
- start pulsed at N+5 during a busy DIV -> ignored, single hilo_we at N+34 with the original result. Back-to-back start at the hilo_we+1 cycle is accepted.
- MULDIV_ACC_EN on: hilo_cur=0x00000000_FFFFFFFF, MADDU 1x1 -> 0x00000001_00000000 at N+MUL_LAT+1. MSUB 1x1 with hilo_cur=0 -> 0xFFFFFFFF_FFFFFFFF.
